// File: rtl/bcd_sevenseg_scan.sv
// Captures a 4-digit packed BCD value and scans it onto a common-anode
// seven-segment display with optional leading-zero blanking.
module bcd_sevenseg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_d_in,
  input  logic        rdy,
  input  logic        lzb,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        valid
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   cap_q, cap_d;
  logic          valid_q, valid_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  logic [3:0] nib [4];
  logic [3:0] nz;
  logic       lead_blank;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = cap_q[4*gi +: 4];
      assign nz[gi]  = |cap_q[4*gi +: 4];
    end
  endgenerate

  // Segment order {g,f,e,d,c,b,a}, active-low; non-decimal nibbles show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    cap_d      = cap_q;
    valid_d    = valid_q;
    an_d       = 4'b1111;
    seg_d      = 7'b1111111;
    lead_blank = 1'b0;

    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    if (rdy) begin
      cap_d   = bcd_d_in;
      valid_d = 1'b1;
    end

    // A digit is a leading zero only if it and every digit above it are zero.
    case (idx_q)
      2'd3:    lead_blank = !nz[3];
      2'd2:    lead_blank = !nz[3] && !nz[2];
      2'd1:    lead_blank = !nz[3] && !nz[2] && !nz[1];
      default: lead_blank = 1'b0;
    endcase

    if (valid_q && !(lzb && lead_blank)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(nib[idx_q]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      cap_q   <= 16'h0000;
      valid_q <= 1'b0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign valid = valid_q;

endmodule

// File: doc/bcd_sevenseg_scan.md
# bcd_sevenseg_scan

Downstream display stage for the 4-bit adder / binary-to-BCD top module. It captures the 16-bit packed BCD result (four digits) whenever `rdy` is high. It then time-multiplexes the four digits onto a common-anode 4-digit seven-segment display. Optional leading-zero blanking is provided, and any nibble above 9 is shown as a dash.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit stays selected. Legal range ≥ 2. Counter width is $clog2(`REFRESH_DIV`).

Ports:
- `clk`, input, 1: system clock. One clock domain; all state updates on the rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `bcd_d_in`, input, 16: packed BCD from the upstream block `bcd_d_out`. Digit0 = [3:0] (ones), digit3 = [15:12].
- `rdy`, input, 1: upstream result valid. Data is captured on every cycle where `rdy`=1.
- `lzb`, input, 1: leading-zero blanking enable. Sampled live, not captured.
- `an`, output, 4: digit anode enables, active-low. Bit i selects digit i.
- `seg`, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- `valid`, output, 1: high once any value has been captured since reset.

## Operation
- **Capture register `cap[15:0]`.**
  - On an edge with `rst`=0 and `rdy`=1: `cap` ← `bcd_d_in`, and `valid` ← 1.
  - `rdy`=0: `cap` holds.
  - `rdy` held high: `cap` tracks the input every cycle; the last value sampled with `rdy`=1 wins.
- **Refresh counter `cnt`.**
  - Increments every cycle.
  - At `cnt` = `REFRESH_DIV`-1: `cnt` ← 0 and digit index `idx` ← (`idx`+1) mod 4.
  - Sequence is 0→1→2→3→0.
- **Digit decode** for the current `idx` (nibble d = `cap[4*idx+3 : 4*idx]`):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10–15 = dash, 0111111.
- **Leading-zero blanking**, applied when `lzb`=1. A nibble >9 counts as nonzero.
  - Digit3 is blank if d3=0.
  - Digit2 is blank if d3=d2=0.
  - Digit1 is blank if d3=d2=d1=0.
  - Digit0 is never blanked.
- **Blanked digit:** `an` = 1111 and `seg` = 1111111 for that slot. The scan timing is unchanged.
- **Before first capture** (`valid`=0): `an` = 1111 and `seg` = 1111111 in every slot. The counter and `idx` still run.
- **Normal slot:** `an` = ~(4'b0001 << `idx`) and `seg` = decode(d).
- **Registered outputs:** `an` and `seg` are registered, computed each cycle from the current `idx`, `cap`, `valid` and `lzb`.
- **Reset** (`rst`=1 at an edge) has priority over `rdy` and produces:
  - `cnt`=0, `idx`=0.
  - `cap`=16'h0000, `valid`=0.
  - `an`=1111, `seg`=1111111.
- **Reset mid-scan:** all state returns to the values above at that edge. The scan restarts at digit0 after `rst` falls.

## Timing
- **Capture latency:** `rdy`=1 sampled at edge N → `cap`/`valid` updated at N. Outputs for the currently selected digit reflect the new value at edge N+1.
- **Digit-change latency:** `idx` advances at edge M → `an`/`seg` show the new digit at edge M+1.
- **Slot length:** each digit occupies exactly `REFRESH_DIV` consecutive cycles of output. The full frame is 4×`REFRESH_DIV` cycles.
- **First output after reset:** after `rst` deasserts at edge R, the first decode of digit0 appears at edge R+1, subject to `valid`.
- **`cnt` wrap and `rdy` in the same cycle:** the two are independent and both take effect; the new digit is decoded from the new `cap`.
- **`lzb` toggle:** takes effect on the next registered output, with 1 cycle latency.
- **No backpressure:** no handshake back to the upstream block. `rdy` is never acknowledged, and data is always accepted.

## Test plan
All scenarios use `REFRESH_DIV`=4.

- **Reset:** hold `rst`=1 for 3 cycles with `rdy`=1 and `bcd_d_in`=16'h1234 → `an`=1111, `seg`=1111111, `valid`=0 throughout. After release, outputs stay blank for a full 16-cycle frame.
- **Basic scan:** one-cycle `rdy` pulse with `bcd_d_in`=16'h0029 (15+14=29), `lzb`=0 → `valid`=1. Over one frame:
  - `an`=1110 with `seg`=0010000.
  - `an`=1101 with `seg`=0100100.
  - `an`=1011 with `seg`=1000000.
  - `an`=0111 with `seg`=1000000.
  - Each slot lasts 4 cycles.
- **Blanking:** same data with `lzb`=1 → digit2/3 slots show `an`=1111 and `seg`=1111111, while digits 0 and 1 are unchanged. `bcd_d_in`=16'h0000 → only digit0 lit, with `seg`=1000000.
- **Invalid nibble:** `bcd_d_in`=16'h00A5 → digit1 slot shows `seg`=0111111 (dash). With `lzb`=1, digit1 is not blanked.
- **Capture semantics:**
  - `rdy` high for 3 cycles with inputs 0001, 0002, 0003 → digit0 shows 3 (0110000).
  - Then `rdy`=0 with `bcd_d_in`=9999 → display still shows 0003.
  - A capture in the middle of a slot changes `seg` exactly 1 cycle later.
- **Reset mid-scan:** pulse `rst` while `idx`=2 → at the next edge `an`=1111, `seg`=1111111, `valid`=0. After release, the scan resumes from digit0 and stays blank until the next `rdy`.
